// File: rtl/cpu_mem_test_pkg.sv
// Shared types for the on-chip memory tester: FSM states, pattern modes and
// the error-counter width.
package cpu_mem_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [1:0] MODE_CONST   = 2'd0;
  localparam logic [1:0] MODE_INC     = 2'd1;
  localparam logic [1:0] MODE_CHECKER = 2'd2;
  localparam logic [1:0] MODE_RSVD    = 2'd3;

  localparam int ERR_CNT_W = 16;

endpackage

// File: rtl/cpu_mem_test_pattern.sv
// Combinational test-pattern generator: word value for a given mode, seed and
// index into the tested range.
module cpu_mem_test_pattern
  import cpu_mem_test_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 11
) (
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic [IDX_W-1:0]  index,
  output logic [DATA_W-1:0] pattern
);

  logic [DATA_W-1:0] index_ext;

  assign index_ext = DATA_W'(index);

  always_comb begin
    pattern = seed;
    case (mode)
      MODE_INC:              pattern = seed + index_ext;
      MODE_CHECKER:          pattern = index[0] ? ~seed : seed;
      MODE_CONST, MODE_RSVD: pattern = seed;
      default:               pattern = seed;
    endcase
  end

endmodule

// File: rtl/cpu_onchip_memory_tester.sv
// Avalon-MM built-in self test master for a single-port on-chip memory:
// fill a word range with a pattern, read it back and count miscompares.
module cpu_onchip_memory_tester
  import cpu_mem_test_pkg::*;
#(
  parameter int ADDR_W       = 10,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ADDR_W-1:0]    base,
  input  logic [ADDR_W:0]      count,
  input  logic [1:0]           mode,
  input  logic [DATA_W-1:0]    seed,
  output logic [ADDR_W-1:0]    address,
  output logic [DATA_W/8-1:0]  byteenable,
  output logic                 chipselect,
  output logic                 write,
  output logic [DATA_W-1:0]    writedata,
  input  logic [DATA_W-1:0]    readdata,
  output logic                 busy,
  output logic                 done,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [ADDR_W-1:0]    first_err_addr,
  output logic                 error,
  output logic [2:0]           state_dbg
);

  localparam int BE_W  = DATA_W / 8;
  localparam int IDX_W = ADDR_W + 1;
  localparam int DRN_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam int LAST  = READ_LATENCY - 1;

  // Control handshake: start is sampled only in IDLE (abort wins if both are
  // high), done pulses for exactly one cycle; the memory has no waitrequest,
  // so every cycle with chipselect=1 is a completed transfer.
  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [1:0]          mode_q, mode_d;
  logic [DATA_W-1:0]   seed_q, seed_d;
  logic [DRN_W-1:0]    drn_q, drn_d;
  logic                clear_res;

  logic [ADDR_W-1:0]   address_q, address_d;
  logic [BE_W-1:0]     byteenable_q, byteenable_d;
  logic                chipselect_q, chipselect_d;
  logic                write_q, write_d;
  logic [DATA_W-1:0]   writedata_q, writedata_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [ERR_CNT_W-1:0] err_q, err_d;
  logic [ADDR_W-1:0]   first_q, first_d;
  logic                error_q, error_d;

  logic                pipe_vld_q [READ_LATENCY];
  logic                pipe_vld_d [READ_LATENCY];
  logic [IDX_W-1:0]    pipe_idx_q [READ_LATENCY];
  logic [IDX_W-1:0]    pipe_idx_d [READ_LATENCY];

  logic [DATA_W-1:0]   wr_pat, exp_pat;
  logic                miscmp;

  cpu_mem_test_pattern #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_wr_pattern (
    .mode    (mode_d),
    .seed    (seed_d),
    .index   (idx_d),
    .pattern (wr_pat)
  );

  cpu_mem_test_pattern #(.DATA_W(DATA_W), .IDX_W(IDX_W)) u_exp_pattern (
    .mode    (mode_q),
    .seed    (seed_q),
    .index   (pipe_idx_q[LAST]),
    .pattern (exp_pat)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    cnt_d     = cnt_q;
    base_d    = base_q;
    mode_d    = mode_q;
    seed_d    = seed_q;
    drn_d     = drn_q;
    clear_res = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          base_d    = base;
          cnt_d     = count;
          mode_d    = mode;
          seed_d    = seed;
          idx_d     = '0;
          clear_res = 1'b1;
          state_d   = (count == '0) ? ST_DONE : ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (idx_q == cnt_q - IDX_W'(1)) begin
          state_d = ST_READ;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_READ: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (idx_q == cnt_q - IDX_W'(1)) begin
          state_d = ST_DRAIN;
          drn_d   = '0;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      ST_DRAIN: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (drn_q == DRN_W'(LAST)) begin
          state_d = ST_DONE;
        end else begin
          drn_d = drn_q + DRN_W'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Bus outputs are registered from the next state so the transfer for
  // index i appears in the same cycle that idx_q holds i.
  always_comb begin
    chipselect_d = (state_d == ST_WRITE) || (state_d == ST_READ);
    write_d      = (state_d == ST_WRITE);
    address_d    = chipselect_d ? base_d + idx_d[ADDR_W-1:0] : '0;
    writedata_d  = write_d ? wr_pat : '0;
    byteenable_d = chipselect_d ? {BE_W{1'b1}} : '0;
    busy_d       = chipselect_d || (state_d == ST_DRAIN);
    done_d       = (state_d == ST_DONE);
  end

  // Index pipeline matching the memory's read latency; flushed in IDLE so an
  // aborted run cannot leak compares into the next one.
  always_comb begin
    pipe_vld_d[0] = chipselect_q & ~write_q;
    pipe_idx_d[0] = idx_q;
    for (int j = 1; j < READ_LATENCY; j++) begin
      pipe_vld_d[j] = pipe_vld_q[j-1];
      pipe_idx_d[j] = pipe_idx_q[j-1];
    end
    if (state_q == ST_IDLE) begin
      for (int j = 0; j < READ_LATENCY; j++) begin
        pipe_vld_d[j] = 1'b0;
      end
    end
  end

  assign miscmp = pipe_vld_q[LAST] && (readdata != exp_pat) &&
                  ((state_q == ST_READ) || (state_q == ST_DRAIN));

  always_comb begin
    err_d   = err_q;
    first_d = first_q;
    if (clear_res) begin
      err_d   = '0;
      first_d = '0;
    end else if (miscmp) begin
      if (err_q != '1) err_d = err_q + ERR_CNT_W'(1);
      if (err_q == '0) first_d = base_q + pipe_idx_q[LAST][ADDR_W-1:0];
    end
    error_d = (err_d != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      base_q       <= '0;
      mode_q       <= '0;
      seed_q       <= '0;
      drn_q        <= '0;
      address_q    <= '0;
      byteenable_q <= '0;
      chipselect_q <= 1'b0;
      write_q      <= 1'b0;
      writedata_q  <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= '0;
      first_q      <= '0;
      error_q      <= 1'b0;
      for (int j = 0; j < READ_LATENCY; j++) begin
        pipe_vld_q[j] <= 1'b0;
        pipe_idx_q[j] <= '0;
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      base_q       <= base_d;
      mode_q       <= mode_d;
      seed_q       <= seed_d;
      drn_q        <= drn_d;
      address_q    <= address_d;
      byteenable_q <= byteenable_d;
      chipselect_q <= chipselect_d;
      write_q      <= write_d;
      writedata_q  <= writedata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      first_q      <= first_d;
      error_q      <= error_d;
      pipe_vld_q   <= pipe_vld_d;
      pipe_idx_q   <= pipe_idx_d;
    end
  end

  assign address        = address_q;
  assign byteenable     = byteenable_q;
  assign chipselect     = chipselect_q;
  assign write          = write_q;
  assign writedata      = writedata_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_count      = err_q;
  assign first_err_addr = first_q;
  assign error          = error_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_cpu_onchip_memory_tester.sv
// Bench for cpu_onchip_memory_tester: two instances (read latency 1 and 2)
// share stimulus, each with its own memory model with an optional stuck bit.
module tb_cpu_onchip_memory_tester;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 1024;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n;
  logic              start, abort;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   count;
  logic [1:0]        mode;
  logic [DATA_W-1:0] seed;

  logic [ADDR_W-1:0] addr1, addr2, first1, first2;
  logic [3:0]        be1, be2;
  logic              cs1, cs2, we1, we2, busy1, busy2, done1, done2, error1, error2;
  logic [DATA_W-1:0] wd1, wd2, rd1, rd2, rd2a;
  logic [15:0]       err1, err2;
  logic [2:0]        st1, st2;

  cpu_onchip_memory_tester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(1)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .base(base), .count(count),
    .mode(mode), .seed(seed), .address(addr1), .byteenable(be1), .chipselect(cs1),
    .write(we1), .writedata(wd1), .readdata(rd1), .busy(busy1), .done(done1),
    .err_count(err1), .first_err_addr(first1), .error(error1), .state_dbg(st1)
  );

  cpu_onchip_memory_tester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .READ_LATENCY(2)) dut_l2 (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .base(base), .count(count),
    .mode(mode), .seed(seed), .address(addr2), .byteenable(be2), .chipselect(cs2),
    .write(we2), .writedata(wd2), .readdata(rd2), .busy(busy2), .done(done2),
    .err_count(err2), .first_err_addr(first2), .error(error2), .state_dbg(st2)
  );

  // ---------------- memory models ----------------
  logic [DATA_W-1:0] mem1 [DEPTH];
  logic [DATA_W-1:0] mem2 [DEPTH];
  int                stuck_addr = -1;
  logic              scrub = 1'b0;
  logic [DATA_W-1:0] scrub_key = '0;

  function automatic logic [DATA_W-1:0] fmask(input logic [ADDR_W-1:0] a);
    return (stuck_addr == int'(a)) ? 32'h1 : 32'h0;
  endfunction

  always @(posedge clk) begin
    if (scrub) begin
      for (int a = 0; a < DEPTH; a++) begin
        mem1[a] <= scrub_key ^ a;
        mem2[a] <= ~scrub_key ^ a;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (cs1 && we1 && be1[b]) mem1[addr1][b*8 +: 8] <= wd1[b*8 +: 8];
        if (cs2 && we2 && be2[b]) mem2[addr2][b*8 +: 8] <= wd2[b*8 +: 8];
      end
    end
    rd1  <= mem1[addr1] | fmask(addr1);
    rd2a <= mem2[addr2] | fmask(addr2);
    rd2  <= rd2a;
  end

  // ---------------- scoreboard / reference model ----------------
  int checks = 0;
  int failures = 0;
  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pat(input logic [1:0] m, input logic [DATA_W-1:0] s, input int i);
    case (m)
      2'd1:    return s + 32'(i);
      2'd2:    return (i % 2 == 1) ? ~s : s;
      default: return s;
    endcase
  endfunction

  task automatic model(input logic [ADDR_W-1:0] b, input int n, input logic [1:0] m,
                       input logic [DATA_W-1:0] s, input int stuck,
                       output int err, output int first);
    err = 0;
    first = 0;
    for (int i = 0; i < n; i++) begin
      int a = (int'(b) + i) % DEPTH;
      logic [DATA_W-1:0] p = pat(m, s, i);
      logic [DATA_W-1:0] seen = p | ((a == stuck) ? 32'h1 : 32'h0);
      if (seen != p) begin
        if (err == 0) first = a;
        err++;
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_bus1"},  {addr1, be1, cs1, we1, busy1, done1, error1}, 64'h0);
    chk({tag, "_wd1"},   wd1, 64'h0);
    chk({tag, "_res1"},  {err1, first1}, 64'h0);
    chk({tag, "_bus2"},  {addr2, be2, cs2, we2, busy2, done2, error2}, 64'h0);
    chk({tag, "_wd2"},   wd2, 64'h0);
    chk({tag, "_res2"},  {err2, first2}, 64'h0);
  endtask

  task automatic issue_start(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n,
                             input logic [1:0] m, input logic [DATA_W-1:0] s);
    @(posedge clk); #1;
    start = 1'b1; base = b; count = n; mode = m; seed = s;
    @(posedge clk); #1;
    start = 1'b0; base = ADDR_W'($urandom); count = 11'($urandom); mode = 2'($urandom); seed = $urandom;
  endtask

  task automatic run_test(input string tag, input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] n,
                          input logic [1:0] m, input logic [DATA_W-1:0] s, input int stuck,
                          input int exp_err, input int exp_first, input int exp_d1, input int exp_d2);
    int nn = int'(n);
    int d1 = -1, d2 = -1, dn1 = 0, dn2 = 0, bad1 = 0, bad2 = 0, sbbad = 0, mbad1 = 0, mbad2 = 0;
    logic [15:0] e1 = '0, e2 = '0;
    logic [ADDR_W-1:0] f1 = '0, f2 = '0;
    logic er1 = 1'b0, er2 = 1'b0;
    @(posedge clk); #1;
    scrub_key = $urandom; scrub = 1'b1; stuck_addr = stuck;
    exp_q.delete();
    for (int i = 0; i < nn; i++) exp_q.push_back({10'((int'(b) + i) % DEPTH), pat(m, s, i)});
    @(posedge clk); #1;
    scrub = 1'b0;
    issue_start(b, n, m, s);
    for (int c = 1; c <= 2 * nn + 8; c++) begin
      logic exp_cs, exp_we;
      logic [ADDR_W-1:0] exp_addr;
      int idx;
      @(negedge clk);
      exp_cs   = (c <= 2 * nn);
      exp_we   = (c <= nn);
      idx      = (c <= nn) ? c - 1 : c - 1 - nn;
      exp_addr = exp_cs ? 10'((int'(b) + idx) % DEPTH) : '0;
      if ({cs1, we1, be1, addr1} !== {exp_cs, exp_we, exp_cs ? 4'hF : 4'h0, exp_addr}) bad1++;
      if ({cs2, we2, be2, addr2} !== {exp_cs, exp_we, exp_cs ? 4'hF : 4'h0, exp_addr}) bad2++;
      if (cs1 && we1) begin
        if (exp_q.size() == 0) sbbad++;
        else if ({addr1, wd1} !== exp_q.pop_front()) sbbad++;
      end
      if (c == 1 && nn > 0) begin
        chk({tag, "_busy1"}, busy1, 1);
        chk({tag, "_busy2"}, busy2, 1);
      end
      if (done1) begin
        dn1++;
        if (d1 < 0) begin d1 = c; e1 = err1; f1 = first1; er1 = error1; end
      end
      if (done2) begin
        dn2++;
        if (d2 < 0) begin d2 = c; e2 = err2; f2 = first2; er2 = error2; end
      end
    end
    for (int i = 0; i < nn; i++) begin
      if (mem1[(int'(b) + i) % DEPTH] !== pat(m, s, i)) mbad1++;
      if (mem2[(int'(b) + i) % DEPTH] !== pat(m, s, i)) mbad2++;
    end
    chk({tag, "_done_cycle_l1"}, 64'(d1), 64'(exp_d1));
    chk({tag, "_done_cycle_l2"}, 64'(d2), 64'(exp_d2));
    chk({tag, "_done_pulses"},   {32'(dn1), 32'(dn2)}, {32'd1, 32'd1});
    chk({tag, "_err_l1"},        e1, 64'(exp_err));
    chk({tag, "_err_l2"},        e2, 64'(exp_err));
    chk({tag, "_first_l1"},      f1, 64'(exp_first));
    chk({tag, "_first_l2"},      f2, 64'(exp_first));
    chk({tag, "_error_flags"},   {er1, er2}, (exp_err != 0) ? 2'b11 : 2'b00);
    chk({tag, "_bus_seq"},       {32'(bad1), 32'(bad2)}, 64'h0);
    chk({tag, "_wr_scoreboard"}, 64'(sbbad + exp_q.size()), 64'h0);
    chk({tag, "_mem_contents"},  {32'(mbad1), 32'(mbad2)}, 64'h0);
    stuck_addr = -1;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   count;
    logic [1:0]        mode;
    logic [DATA_W-1:0] seed;
    int                stuck;
    int                exp_err;
    int                exp_first;
    int                exp_d1;
    int                exp_d2;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{10'd0,    11'd1024, 2'd1, 32'h0000_0000, -1,  0, 0,   2050, 2051};
    vecs[1] = '{10'd1020, 11'd8,    2'd2, 32'hA5A5_A5A5, -1,  0, 0,   18,   19};
    vecs[2] = '{10'd0,    11'd16,   2'd0, 32'h0000_0000, 5,   1, 5,   34,   35};
    vecs[3] = '{10'd7,    11'd0,    2'd1, 32'h0000_1234, -1,  0, 0,   1,    1};
    vecs[4] = '{10'd100,  11'd5,    2'd3, 32'h1234_5678, 102, 1, 102, 12,   13};
    vecs[5] = '{10'd1022, 11'd4,    2'd1, 32'hFFFF_FFFE, 0,   1, 0,   10,   11};
    vecs[6] = '{10'd10,   11'd6,    2'd2, 32'h0000_0000, 11,  0, 0,   14,   15};

    reset_n = 1'b0; start = 1'b0; abort = 1'b0;
    base = '0; count = '0; mode = '0; seed = '0;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    reset_n = 1'b1;

    for (int v = 0; v < 7; v++) begin
      run_test($sformatf("vec%0d", v), vecs[v].base, vecs[v].count, vecs[v].mode, vecs[v].seed,
               vecs[v].stuck, vecs[v].exp_err, vecs[v].exp_first, vecs[v].exp_d1, vecs[v].exp_d2);
      if (v == 0) chk("vec0_word1023", mem1[1023], 64'h3FF);
    end

    // Abort in the third write cycle: bus idle and busy low the next cycle, no done.
    begin
      int dn = 0;
      issue_start(10'd0, 11'd100, 2'd1, 32'h0);
      repeat (3) @(negedge clk);
      chk("abort_running", {cs1, we1, cs2, we2}, 4'hF);
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      chk("abort_bus_idle", {cs1, we1, busy1, cs2, we2, busy2}, 6'h0);
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        if (done1 || done2 || cs1 || cs2) dn++;
      end
      chk("abort_no_done", 64'(dn), 64'h0);
      chk("abort_results", {err1, err2}, 32'h0);
    end
    run_test("after_abort", 10'd1020, 11'd8, 2'd2, 32'hA5A5_A5A5, -1, 0, 0, 18, 19);

    // Start and abort together in IDLE: abort wins.
    begin
      int act = 0;
      @(posedge clk); #1;
      start = 1'b1; abort = 1'b1; base = 10'd3; count = 11'd5; mode = 2'd0; seed = 32'h1;
      @(posedge clk); #1;
      start = 1'b0; abort = 1'b0;
      for (int c = 0; c < 14; c++) begin
        @(negedge clk);
        if (busy1 || busy2 || cs1 || cs2 || done1 || done2) act++;
      end
      chk("start_abort_idle", 64'(act), 64'h0);
    end

    // Reset in the middle of the read phase.
    issue_start(10'd0, 11'd16, 2'd1, 32'h0);
    repeat (19) @(negedge clk);
    chk("midread_reading", {cs1, we1}, 2'b10);
    reset_n = 1'b0;
    #1;
    chk_idle_outputs("midread_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    run_test("rerun", vecs[0].base, vecs[0].count, vecs[0].mode, vecs[0].seed,
             -1, 0, 0, 2050, 2051);

    // Randomised runs checked against the reference model.
    for (int r = 0; r < 8; r++) begin
      int n, e, f, st;
      logic [ADDR_W-1:0] b;
      logic [1:0] m;
      logic [DATA_W-1:0] s;
      n  = $urandom_range(0, 40);
      b  = 10'($urandom_range(0, DEPTH - 1));
      m  = 2'($urandom_range(0, 3));
      s  = $urandom;
      st = (n > 0 && $urandom_range(0, 1) == 1) ? (int'(b) + $urandom_range(0, n - 1)) % DEPTH : -1;
      model(b, n, m, s, st, e, f);
      run_test($sformatf("rand%0d", r), b, 11'(n), m, s, st, e, f,
               (n == 0) ? 1 : 2 * n + 2, (n == 0) ? 1 : 2 * n + 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
